load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side load/store unit between the core's execute stage and the word-wide data memory. Accepts byte, halfword and word loads/stores over a valid/ready request channel. Sub-word stores become read-modify-write sequences against the memory's aligned word write port. Returns sign- or zero-extended load data, or an error, on a response channel.

## Interface

Parameters:
- `WORDS`, 64: data memory depth in 32-bit words.
- `DATA_WIDTH`, 32: address and data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- `req_unsigned`  in  1  loads only: zero-extend when 1, sign-extend when 0.
- `req_addr`  in  DATA_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access, illegal size, or out-of-range access.
- `mem_addr`  out  DATA_WIDTH  word-aligned byte address to memory; bits [1:0] always 00.
- `mem_rdata`  in  DATA_WIDTH  memory read data, combinational from `mem_addr`.
- `mem_wdata`  out  DATA_WIDTH  full word to write.
- `mem_write`  out  1  write strobe; memory commits on the same rising edge.

## Operation

- States: IDLE, RD, WR, DONE.
- `req_ready` = (state == IDLE).
- Handshake is `req_valid && req_ready`. On handshake, latch addr, size, write, unsigned and wdata.
- Error check on accept. An error sends IDLE -> DONE with `resp_err`=1 and no memory cycle. Error conditions:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠00.
- Legal accept transitions:
  - Load: IDLE -> RD.
  - Word store: IDLE -> WR.
  - Byte or half store: IDLE -> RD.
- RD, load:
  - Select the byte or half lane by addr[1:0], little-endian.
  - Extend it and register it into `resp_rdata`.
  - Go to DONE.
- RD, sub-word store:
  - Capture `mem_rdata` and replace only the addressed lane(s) with the low bits of wdata.
  - Go to WR.
- WR: `mem_write`=1 for exactly one cycle, `mem_wdata` = latched word or merged word. Go to DONE.
- DONE: `resp_valid`=1. Leave for IDLE only on a cycle where `resp_ready`=1. Outputs are stable while stalled.
- `mem_addr` = {latched addr[DATA_WIDTH-1:2], 2'b00} in RD and WR, and 0 in IDLE and DONE.
- `mem_write` is decoded from state (WR) only. It is never asserted in any other state.
- Word-index arithmetic is unsigned, on addr[DATA_WIDTH-1:2].

## Timing

- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset takes effect immediately, including mid-RMW. Asserting `rst` in RD or WR drops `mem_write` combinationally and no partial write occurs after release.
- Latency, handshake edge to first `resp_valid` cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: no new request is accepted before the response handshake completes. With `resp_ready` held high, back-to-back loads issue every 3 cycles.
- A request presented during DONE is held off (`req_ready`=0) and accepted in the cycle after the response handshake.
- `mem_rdata` is sampled at the end of the RD cycle. The memory's read is combinational, so no wait state is needed.

## Configuration

- `LSU_RANGE_CHECK_EN` defined: an access whose word index (addr[DATA_WIDTH-1:2]) is ≥ `WORDS` is an error. It goes IDLE -> DONE with `resp_err`=1 and no memory cycle.
- Undefined: no range check. The index is passed to memory unmodified, and out-of-range behaviour is the memory's.

## Test plan

- Word store 0xDEADBEEF to 0x10, then word load from 0x10. Required: `mem_write` pulses exactly once, and the load returns 0xDEADBEEF with `resp_err`=0 two cycles after its handshake.
- Memory word at 0x20 = 0x11223344. Signed byte load from 0x23 returns 0x00000011. Signed half load from 0x22 returns 0x00001122. Set the word to 0x80FF0000: signed byte load from 0x22 returns 0xFFFFFFFF, and unsigned half load from 0x22 returns 0x000080FF.
- Word at 0x30 = 0xAABBCCDD. Byte store 0x55 to 0x31 leaves memory at 0xAABB55DD. A following half store 0x1234 to 0x32 leaves 0x123455DD. Each store takes 3 cycles to `resp_valid`.
- Error cases: half load at 0x05, word store at 0x06, and size 11 each give `resp_err`=1 one cycle after handshake, with `mem_write` never asserted and memory unchanged. With `LSU_RANGE_CHECK_EN` and `WORDS`=64, a word load at 0x100 gives `resp_err`=1.
- Hold `resp_ready`=0 for 5 cycles in DONE. Required: `resp_valid`, `resp_rdata` and `resp_err` stay stable, `req_ready`=0, and a pending request is accepted only after the response handshake.
- Assert `rst` during the WR cycle of a byte store. Required: `mem_write` drops immediately, the unit is in IDLE with `req_ready`=1, and a following load completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide memory; sub-word stores use read-modify-write.
// Optional build macro LSU_RANGE_CHECK_EN flags accesses whose word index is >= WORDS as errors.
module load_store_unit #(
    parameter int WORDS      = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write
);

    // state | meaning
    // IDLE  | ready for a request
    // RD    | memory read: load lane extract, or RMW merge for sub-word store
    // WR    | single-cycle aligned word write
    // DONE  | response presented until resp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_size;
    logic                  r_write;
    logic                  r_unsigned;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_align_err;
    logic                  w_range_err;
    logic                  w_req_err;
    logic [4:0]            w_lane_shift;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic [DATA_WIDTH-1:0] w_lane_data;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_word_addr;

    assign w_accept = req_valid && req_ready;

    assign w_align_err = (req_size == SZ_BAD)
                      || ((req_size == SZ_HALF) && req_addr[0])
                      || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
    localparam logic [DATA_WIDTH-3:0] WORDS_LIMIT = (DATA_WIDTH-2)'(WORDS);
    assign w_range_err = (req_addr[DATA_WIDTH-1:2] >= WORDS_LIMIT);
`else
    assign w_range_err = 1'b0;
`endif

    assign w_req_err = w_align_err || w_range_err;

    // Little-endian lane selection from the latched byte offset.
    assign w_lane_shift = {r_addr[1:0], 3'b000};

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
    end

    assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_load_val = mem_rdata;
        case (r_size)
            SZ_BYTE: w_load_val = {{(DATA_WIDTH-8){~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_val = {{(DATA_WIDTH-16){~r_unsigned & w_half[15]}}, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    always_comb begin
        w_lane_mask = '1;
        case (r_size)
            SZ_BYTE: w_lane_mask = DATA_WIDTH'(8'hFF) << w_lane_shift;
            SZ_HALF: w_lane_mask = DATA_WIDTH'(16'hFFFF) << w_lane_shift;
            default: w_lane_mask = '1;
        endcase
    end

    assign w_lane_data = r_wdata << w_lane_shift;
    assign w_merged    = (mem_rdata & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    assign w_word_addr = {r_addr[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = DONE;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = r_write ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = resp_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // mem_write comes from state alone so an async reset removes it immediately.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            IDLE: req_ready = 1'b1;
            RD:   mem_addr  = w_word_addr;
            WR: begin
                mem_addr  = w_word_addr;
                mem_write = 1'b1;
                mem_wdata = r_wdata;
            end
            DONE:    resp_valid = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_size     <= SZ_BYTE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_err      <= w_req_err;
            r_rdata    <= '0;
        end else if (r_state == RD) begin
            if (r_write) begin
                r_wdata <= w_merged;
            end else begin
                r_rdata <= w_load_val;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed cases and random traffic.
// Honours LSU_RANGE_CHECK_EN the same way the design does.
module tb_load_store_unit;
    localparam int WORDS = 64;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem_wdata;
    logic          mem_write;

    load_store_unit #(.WORDS(WORDS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          hs;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:WORDS-1];
    logic [7:0]  ref_b [0:4*WORDS-1];
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          exp_wr = 0;
    int          last_hs = 0;
    int          resp_hs = 0;
    bit          poke_en = 1'b0;
    logic [5:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    bit          rand_stall = 1'b0;
    bit          rr_force = 1'b1;

    assign mem_rdata = mem[mem_addr[7:2]];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: memory as bytes; sizes, alignment and extension computed arithmetically.
    function automatic exp_t model(bit w, logic [1:0] sz, bit u, logic [31:0] a, logic [31:0] wd, int hs);
        exp_t   e;
        int     n;
        longint v;
        bit     bad;
        e.hs = hs;
        e.rdata = '0;
        e.err = 1'b0;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3) || ((a % n) != 0);
`ifdef LSU_RANGE_CHECK_EN
        if ((a / 4) >= WORDS) bad = 1'b1;
`endif
        if (bad) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        if (w) begin
            for (int i = 0; i < n; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
            exp_wr++;
            e.lat = (n == 4) ? 2 : 3;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_b[int'(a) + i]) << (8*i);
            if (!u && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
            e.rdata = v[31:0];
            e.lat = 2;
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end
    end

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = rand_stall ? ($urandom_range(0, 3) != 0) : rr_force;
        end
    end

    initial begin : monitor
        bit          in_resp;
        logic [31:0] s_rd;
        logic        s_err;
        exp_t        e;
        in_resp = 1'b0;
        s_rd = '0;
        s_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_resp = 1'b0;
            end else if (resp_valid) begin
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("latency", 32'(cyc - e.hs + 1), 32'(e.lat));
                    end
                    s_rd = resp_rdata;
                    s_err = resp_err;
                    in_resp = 1'b1;
                end else begin
                    check("stall_rdata", resp_rdata, s_rd);
                    check("stall_err", 32'(resp_err), 32'(s_err));
                end
                check("req_ready_in_done", 32'(req_ready), 32'd0);
                if (resp_ready) resp_hs = cyc + 1;
            end else begin
                in_resp = 1'b0;
            end
        end
    end

    task automatic issue(bit w, logic [1:0] sz, bit u, logic [31:0] a, logic [31:0] wd);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (req_ready && !rst) begin
                last_hs = cyc + 1;
                exp_q.push_back(model(w, sz, u, a, wd, last_hs));
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || resp_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic poke(logic [31:0] a, logic [31:0] v);
        @(posedge clk);
        #1;
        poke_idx = a[7:2]; poke_val = v; poke_en = 1'b1;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[int'({a[7:2], 2'b00}) + i] = v[8*i +: 8];
    endtask

    initial begin : main
        int          wr0;
        int          h1;
        int          k;
        logic [31:0] saved;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        for (int w = 0; w < WORDS; w++) poke(32'(w * 4), $urandom);
        @(negedge clk);
        rst = 1'b0;

        wr0 = wr_cnt;
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        drain();
        check("word_store_writes", 32'(wr_cnt - wr0), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drain();
        check("mem_0x10", mem[4], 32'hDEADBEEF);

        poke(32'h20, 32'h11223344);
        issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        drain();
        poke(32'h20, 32'h80FF0000);
        issue(1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        drain();

        poke(32'h30, 32'hAABBCCDD);
        issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h00000055);
        drain();
        check("byte_store_0x31", mem[12], 32'hAABB55DD);
        issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h00001234);
        drain();
        check("half_store_0x32", mem[12], 32'h123455DD);

        wr0 = wr_cnt;
        saved = mem[1];
        issue(1'b0, 2'd1, 1'b0, 32'h05, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFEF00D);
        issue(1'b1, 2'd3, 1'b0, 32'h08, 32'h12345678);
        drain();
        check("err_no_writes", 32'(wr_cnt - wr0), 32'd0);
        check("err_mem_unchanged", mem[1], saved);
`ifdef LSU_RANGE_CHECK_EN
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        drain();
        check("range_no_writes", 32'(wr_cnt - wr0), 32'd0);
`endif

        // Response stalled 5 cycles with a second request waiting.
        rr_force = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("stall_resp_seen", 32'(resp_valid), 32'd1);
        req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h21;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_resp_valid", 32'(resp_valid), 32'd1);
        end
        rr_force = 1'b1;
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
        check("accept_after_resp_hs", 32'(last_hs), 32'(resp_hs + 1));
        drain();

        // Reset in the write cycle of a byte store.
        poke(32'h40, 32'h01020304);
        issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000EE);
        k = 0;
        while (!mem_write && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("rmw_reached_wr", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_drops_mem_write", 32'(mem_write), 32'd0);
        check("rst_req_ready_mid", 32'(req_ready), 32'd1);
        check("rst_resp_valid_mid", 32'(resp_valid), 32'd0);
        exp_q.delete();
        ref_b[8'h41] = 8'h03;
        exp_wr--;
        @(posedge clk);
        #1;
        check("no_partial_write", mem[16], 32'h01020304);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        drain();

        rr_force = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        h1 = last_hs;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        check("b2b_interval", 32'(last_hs - h1), 32'd3);
        drain();

        rand_stall = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
`ifdef LSU_RANGE_CHECK_EN
            if ($urandom_range(0, 7) == 0) a = a + 32'h100;
`endif
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        rand_stall = 1'b0;
        drain();

        for (int w = 0; w < WORDS; w++)
            check("final_mem", mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
        check("total_writes", 32'(wr_cnt), 32'(exp_wr));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
